// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter that assembles NBYTES-wide little-endian words from a byte-wide SPI
// flash controller. Define FLASH_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module flash_read_arbiter #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned AW     = 24
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  req0_valid,
    input  logic [AW-1:0]         req0_addr,
    output logic [8*NBYTES-1:0]   req0_data,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [AW-1:0]         req1_addr,
    output logic [8*NBYTES-1:0]   req1_data,
    output logic                  req1_ready,

    output logic                  flash_valid,
    output logic [AW-1:0]         flash_addr,
    input  logic [7:0]            flash_data,
    input  logic                  flash_ready
);

    localparam int unsigned DW = 8 * NBYTES;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRdy,
        StRelease,
        StDone
    } state_t;

    state_t          state_q;
    logic            grant_q;
    logic [AW-1:0]   base_q;
    logic [1:0]      idx_q;
    logic [DW-1:0]   word_q;

    logic            any_req;
    logic            grant_sel;
    logic            last_idx;
    logic            grant_now;

    assign any_req   = req0_valid | req1_valid;
    assign last_idx  = (idx_q == 2'(NBYTES - 1));
    // Also waits out a flash_ready left high by a transaction abandoned at reset.
    assign grant_now = (state_q == StIdle) && any_req && !flash_ready;

`ifdef FLASH_ARB_RR_EN
    logic last_grant_q;

    always_comb begin
        grant_sel = ~req0_valid;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end
    end

    // Resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rstn) begin
            last_grant_q <= 1'b1;
        end else if (grant_now) begin
            last_grant_q <= grant_sel;
        end
    end
`else
    assign grant_sel = ~req0_valid;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            base_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            flash_valid <= 1'b0;
            flash_addr  <= '0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_data   <= '0;
            req1_data   <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_now) begin
                        grant_q <= grant_sel;
                        base_q  <= grant_sel ? req1_addr : req0_addr;
                        idx_q   <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    flash_valid <= 1'b1;
                    flash_addr  <= base_q + AW'(idx_q);
                    state_q     <= StWaitRdy;
                end
                StWaitRdy: begin
                    if (flash_ready) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (idx_q == 2'(b)) begin
                                word_q[8*b +: 8] <= flash_data;
                            end
                        end
                        flash_valid <= 1'b0;
                        state_q     <= StRelease;
                    end
                end
                StRelease: begin
                    if (!flash_ready) begin
                        if (last_idx) begin
                            // Outputs update only on completion so each requester keeps its last word.
                            if (grant_q) begin
                                req1_ready <= 1'b1;
                                req1_data  <= word_q;
                            end else begin
                                req0_ready <= 1'b1;
                                req0_data  <= word_q;
                            end
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ready_exclusive: assert property (@(posedge clk) disable iff (rstn)
        !(req0_ready && req1_ready));
    a_issue_after_release: assert property (@(posedge clk) disable iff (rstn)
        $rose(flash_valid) |-> !flash_ready);
`endif

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a byte-wide flash model of adjustable latency and
// adjustable flash_ready hold time.
module tb_flash_read_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned AW = 24;
    localparam int          BOUND = 500;

`ifdef FLASH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              req0_valid, req1_valid;
    logic [AW-1:0]     req0_addr, req1_addr;
    logic [8*NB-1:0]   req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              flash_valid;
    logic [AW-1:0]     flash_addr;
    logic [7:0]        flash_data = 8'h00;
    logic              flash_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    int lat  = 0;
    int hold = 0;
    int cnt  = 0;
    int hcnt = 0;

    logic [AW-1:0] addr_q[$];
    int            r0_cnt = 0;
    int            r1_cnt = 0;
    int            viol   = 0;
    logic          fv_prev = 1'b0;

    always #5 clk = ~clk;

    flash_read_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .flash_valid (flash_valid),
        .flash_addr  (flash_addr),
        .flash_data  (flash_data),
        .flash_ready (flash_ready)
    );

    // Flash content: 0x11*(a[1:0]+1) xor {a[5:2],4'h0}
    function automatic logic [7:0] byte_of(input logic [AW-1:0] a);
        logic [7:0] n;
        n = {6'd0, a[1:0]} + 8'd1;
        return (8'h11 * n) ^ {a[5:2], 4'h0};
    endfunction

    always @(posedge clk) begin
        if (flash_valid && !flash_ready) begin
            if (cnt >= lat) begin
                flash_ready <= 1'b1;
                flash_data  <= byte_of(flash_addr);
                cnt         <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else if (!flash_valid && flash_ready) begin
            if (hcnt >= hold) begin
                flash_ready <= 1'b0;
                hcnt        <= 0;
            end else begin
                hcnt <= hcnt + 1;
            end
        end
        if (!flash_valid) cnt <= 0;
    end

    always @(negedge clk) begin
        if (flash_valid && !fv_prev) begin
            addr_q.push_back(flash_addr);
            if (flash_ready) viol++;
        end
        fv_prev = flash_valid;
        if (req0_ready) r0_cnt++;
        if (req1_ready) r1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drops valid (and scrambles the address) after drop_after ticks when nonzero.
    task automatic run_txn(input bit who, input logic [AW-1:0] addr, input int drop_after,
                           output int cycles);
        bit got;
        got = 1'b0;
        if (who) begin
            req1_valid = 1'b1;
            req1_addr  = addr;
        end else begin
            req0_valid = 1'b1;
            req0_addr  = addr;
        end
        cycles = 0;
        while (!got && cycles < BOUND) begin
            tick();
            cycles++;
            if (drop_after != 0 && cycles == drop_after) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                req0_addr  = ~addr;
                req1_addr  = ~addr;
            end
            got = who ? req1_ready : req0_ready;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_timeout req%0d: no ready within %0d cycles", who, BOUND);
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        repeat (3) tick();
        checks++;
        if (flash_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flash_valid got %b want 0", flash_valid);
        end
        checks++;
        if (flash_addr !== '0) begin
            errors++; $display("FAIL reset_flash_addr got %h want 000000", flash_addr);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (req0_data !== '0 || req1_data !== '0) begin
            errors++; $display("FAIL reset_data got %h %h want 0 0", req0_data, req1_data);
        end
        rstn = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_read();
        int cyc, a0, p0, p1;
        lat = 0; hold = 0;
        a0 = addr_q.size(); p0 = r0_cnt; p1 = r1_cnt;
        run_txn(1'b0, 24'h000100, 0, cyc);
        repeat (3) tick();
        checks++;
        if (req0_data !== 32'h44332211) begin
            errors++; $display("FAIL single_data got %h want 44332211", req0_data);
        end
        checks++;
        if (cyc != 21) begin
            errors++; $display("FAIL single_latency got %0d want 21", cyc);
        end
        checks++;
        if (addr_q.size() - a0 != 4) begin
            errors++; $display("FAIL single_addr_count got %0d want 4", addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_q[a0+i] !== 24'h000100 + 24'(i)) begin
                    errors++;
                    $display("FAIL single_addr%0d got %h want %h", i, addr_q[a0+i],
                             24'h000100 + 24'(i));
                end
            end
        end
        checks++;
        if (r0_cnt - p0 != 1 || r1_cnt - p1 != 0) begin
            errors++;
            $display("FAIL single_pulses got r0=%0d r1=%0d want 1 0", r0_cnt - p0, r1_cnt - p1);
        end
    endtask

    task automatic test_wrap();
        int cyc, a0;
        logic [AW-1:0] exp_a[4];
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        a0 = addr_q.size();
        // Requester drops valid and changes addr early; latched address must still be used.
        run_txn(1'b1, 24'hFFFFFE, 3, cyc);
        repeat (2) tick();
        checks++;
        if (req1_data !== 32'h2211B4C3) begin
            errors++; $display("FAIL wrap_data got %h want 2211b4c3", req1_data);
        end
        checks++;
        if (req0_data !== 32'h44332211) begin
            errors++; $display("FAIL wrap_req0_hold got %h want 44332211", req0_data);
        end
        checks++;
        if (addr_q.size() - a0 != 4) begin
            errors++; $display("FAIL wrap_addr_count got %0d want 4", addr_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_q[a0+i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d got %h want %h", i, addr_q[a0+i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        bit exp_g[3];
        bit g;
        bit got;
        int cyc, p0, p1;
        exp_g[0] = 1'b0; exp_g[1] = RR; exp_g[2] = 1'b0;
        p0 = r0_cnt; p1 = r1_cnt;
        req0_addr = 24'h000204; req1_addr = 24'h000308;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0; cyc = 0; g = 1'b0;
            while (!got && cyc < BOUND) begin
                tick();
                cyc++;
                got = req0_ready | req1_ready;
                g   = req1_ready;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL arb_timeout grant%0d", k);
            end else if (g !== exp_g[k]) begin
                errors++; $display("FAIL arb_grant%0d got %0d want %0d", k, g, exp_g[k]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (req0_data !== 32'h54233201) begin
            errors++; $display("FAIL arb_req0_data got %h want 54233201", req0_data);
        end
        checks++;
        if (r0_cnt - p0 != (RR ? 2 : 3) || r1_cnt - p1 != (RR ? 1 : 0)) begin
            errors++;
            $display("FAIL arb_pulses got r0=%0d r1=%0d want %0d %0d", r0_cnt - p0,
                     r1_cnt - p1, RR ? 2 : 3, RR ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, a0, p0, p1;
        lat = 3; hold = 0;
        a0 = addr_q.size(); p0 = r0_cnt; p1 = r1_cnt;
        req0_addr = 24'h000100; req0_valid = 1'b1;
        cyc = 0;
        while (addr_q.size() - a0 < 3 && cyc < BOUND) begin
            tick();
            cyc++;
        end
        checks++;
        if (flash_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_third_byte flash_valid got %b want 1", flash_valid);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (flash_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_flash_valid got %b want 0", flash_valid);
        end
        req0_valid = 1'b0;
        tick();
        rstn = 1'b0;
        repeat (10) tick();
        checks++;
        if (r0_cnt - p0 != 0 || r1_cnt - p1 != 0) begin
            errors++;
            $display("FAIL rstmid_no_pulse got r0=%0d r1=%0d want 0 0", r0_cnt - p0, r1_cnt - p1);
        end
        checks++;
        if (req0_data !== '0) begin
            errors++; $display("FAIL rstmid_data_cleared got %h want 0", req0_data);
        end
        lat = 0;
        a0 = addr_q.size();
        run_txn(1'b1, 24'h000100, 0, cyc);
        repeat (2) tick();
        checks++;
        if (req1_data !== 32'h44332211 || addr_q.size() - a0 != 4) begin
            errors++;
            $display("FAIL rstmid_recover got data=%h bytes=%0d want 44332211 4", req1_data,
                     addr_q.size() - a0);
        end
    endtask

    task automatic test_ready_hold();
        int cyc, v0;
        lat = 0; hold = 5;
        v0 = viol;
        run_txn(1'b0, 24'h000000, 0, cyc);
        repeat (8) tick();
        checks++;
        if (cyc != 41) begin
            errors++; $display("FAIL hold_latency got %0d want 41", cyc);
        end
        checks++;
        if (req0_data !== 32'h44332211) begin
            errors++; $display("FAIL hold_data got %h want 44332211", req0_data);
        end
        checks++;
        if (viol - v0 != 0) begin
            errors++; $display("FAIL hold_issue_overlap got %0d want 0", viol - v0);
        end
        hold = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wrap();
        test_arbitration();
        test_reset_mid();
        test_ready_hold();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL issue_while_ready got %0d want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
